// File: rtl/debug_hex_overlay.sv
// Hex debug text overlay: snapshots NUM_CHANNELS values per frame and renders them as
// 8x8 hex glyphs (one channel per text row) through a fixed 3-stage pixel pipeline.
module debug_hex_overlay #(
    parameter int NUM_CHANNELS = 2,
    parameter int DIGITS       = 4,
    parameter int COORD_W      = 11,
    parameter int ORIGIN_X     = 16,
    parameter int ORIGIN_Y     = 8,
    parameter int SCALE_LOG2   = 0
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             frame_start,
    input  logic                             freeze,
    input  logic [NUM_CHANNELS*DIGITS*4-1:0] values,
    input  logic                             pixel_valid,
    input  logic [COORD_W-1:0]               pixel_x,
    input  logic [COORD_W-1:0]               pixel_y,
    output logic                             overlay_valid,
    output logic                             overlay_bg,
    output logic                             overlay_pixel
);
    localparam int VAL_W = NUM_CHANNELS * DIGITS * 4;
    localparam int SHIFT = 3 + SCALE_LOG2;
    localparam logic [COORD_W:0] BOX_W = (COORD_W+1)'(DIGITS << SHIFT);
    localparam logic [COORD_W:0] BOX_H = (COORD_W+1)'(NUM_CHANNELS << SHIFT);
    localparam logic [COORD_W:0] ORG_X = (COORD_W+1)'(ORIGIN_X);
    localparam logic [COORD_W:0] ORG_Y = (COORD_W+1)'(ORIGIN_Y);

    // Glyph rows 2..6 packed MSB-first; rows 0, 1 and 7 are always blank.
    function automatic logic [39:0] glyph_rows(input logic [3:0] nib);
        case (nib)
            4'h0:    glyph_rows = 40'h7E_42_42_42_7E;
            4'h1:    glyph_rows = 40'h10_10_10_10_10;
            4'h2:    glyph_rows = 40'h7E_02_7E_40_7E;
            4'h3:    glyph_rows = 40'h7E_02_3E_02_7E;
            4'h4:    glyph_rows = 40'h42_42_7E_02_02;
            4'h5:    glyph_rows = 40'h7E_40_7E_02_7E;
            4'h6:    glyph_rows = 40'h7E_40_7E_42_7E;
            4'h7:    glyph_rows = 40'h7E_02_04_08_08;
            4'h8:    glyph_rows = 40'h7E_42_7E_42_7E;
            4'h9:    glyph_rows = 40'h7E_42_7E_02_7E;
            4'hA:    glyph_rows = 40'h3C_42_7E_42_42;
            4'hB:    glyph_rows = 40'h7C_42_7C_42_7C;
            4'hC:    glyph_rows = 40'h7E_40_40_40_7E;
            4'hD:    glyph_rows = 40'h7C_42_42_42_7C;
            4'hE:    glyph_rows = 40'h7E_40_7C_40_7E;
            4'hF:    glyph_rows = 40'h7E_40_7E_40_40;
            default: glyph_rows = 40'h00_00_00_00_00;
        endcase
    endfunction

    function automatic logic [7:0] font_row(input logic [3:0] nib, input logic [2:0] gy);
        logic [39:0] rows;
        rows = glyph_rows(nib);
        case (gy)
            3'd2:    font_row = rows[39:32];
            3'd3:    font_row = rows[31:24];
            3'd4:    font_row = rows[23:16];
            3'd5:    font_row = rows[15:8];
            3'd6:    font_row = rows[7:0];
            default: font_row = 8'h00;
        endcase
    endfunction

    logic [VAL_W-1:0]   snap_q, snap_d;
    logic               v1_q, v1_d, in1_q, in1_d;
    logic [3:0]         nib1_q, nib1_d;
    logic [2:0]         gx1_q, gx1_d, gy1_q, gy1_d;
    logic               v2_q, v2_d, in2_q, in2_d;
    logic [7:0]         row2_q, row2_d;
    logic [2:0]         gx2_q, gx2_d;
    logic               valid_q, valid_d, bg_q, bg_d, pix_q, pix_d;

    logic [COORD_W:0]   dx_ext_s, dy_ext_s;
    logic [COORD_W-1:0] dig_s, chn_s;

    // Next-state logic: snapshot capture and the three pipeline stages.
    always_comb begin
        snap_d   = (frame_start && !freeze) ? values : snap_q;

        // The extra MSB is the borrow, so coordinates left/above the origin never alias.
        dx_ext_s = {1'b0, pixel_x} - ORG_X;
        dy_ext_s = {1'b0, pixel_y} - ORG_Y;
        dig_s    = dx_ext_s[COORD_W-1:0] >> SHIFT;
        chn_s    = dy_ext_s[COORD_W-1:0] >> SHIFT;

        v1_d     = pixel_valid;
        in1_d    = !dx_ext_s[COORD_W] && !dy_ext_s[COORD_W] &&
                   (dx_ext_s < BOX_W) && (dy_ext_s < BOX_H);
        gx1_d    = dx_ext_s[SCALE_LOG2 +: 3];
        gy1_d    = dy_ext_s[SCALE_LOG2 +: 3];
        nib1_d   = 4'h0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            for (int dg = 0; dg < DIGITS; dg++) begin
                if (chn_s == COORD_W'(ch) && dig_s == COORD_W'(dg)) begin
                    nib1_d = snap_q[ch*DIGITS*4 + (DIGITS-1-dg)*4 +: 4];
                end else begin
                    nib1_d = nib1_d;
                end
            end
        end

        v2_d     = v1_q;
        in2_d    = in1_q;
        row2_d   = font_row(nib1_q, gy1_q);
        gx2_d    = gx1_q;

        valid_d  = v2_q;
        bg_d     = v2_q & in2_q;
        pix_d    = v2_q & in2_q & row2_q[3'd7 - gx2_q];
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            snap_q  <= '0;
            v1_q    <= 1'b0;
            in1_q   <= 1'b0;
            nib1_q  <= 4'h0;
            gx1_q   <= 3'd0;
            gy1_q   <= 3'd0;
            v2_q    <= 1'b0;
            in2_q   <= 1'b0;
            row2_q  <= 8'h00;
            gx2_q   <= 3'd0;
            valid_q <= 1'b0;
            bg_q    <= 1'b0;
            pix_q   <= 1'b0;
        end else begin
            snap_q  <= snap_d;
            v1_q    <= v1_d;
            in1_q   <= in1_d;
            nib1_q  <= nib1_d;
            gx1_q   <= gx1_d;
            gy1_q   <= gy1_d;
            v2_q    <= v2_d;
            in2_q   <= in2_d;
            row2_q  <= row2_d;
            gx2_q   <= gx2_d;
            valid_q <= valid_d;
            bg_q    <= bg_d;
            pix_q   <= pix_d;
        end
    end

    assign overlay_valid = valid_q;
    assign overlay_bg    = bg_q;
    assign overlay_pixel = pix_q;
endmodule

// File: tb/tb_debug_hex_overlay.sv
// Directed bench for debug_hex_overlay: a SCALE_LOG2=0 and a SCALE_LOG2=1 instance share all inputs.
module tb_debug_hex_overlay;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        freeze = 1'b0;
    logic [31:0] values = 32'h0;
    logic        pixel_valid = 1'b0;
    logic [10:0] pixel_x = 11'd0;
    logic [10:0] pixel_y = 11'd0;
    logic        ov0, bg0, px0, ov1, bg1, px1;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clock = ~clock;

    debug_hex_overlay #(.SCALE_LOG2(0)) dut0 (
        .clock(clock), .reset_n(reset_n), .frame_start(frame_start), .freeze(freeze),
        .values(values), .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .overlay_valid(ov0), .overlay_bg(bg0), .overlay_pixel(px0));

    debug_hex_overlay #(.SCALE_LOG2(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .frame_start(frame_start), .freeze(freeze),
        .values(values), .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .overlay_valid(ov1), .overlay_bg(bg1), .overlay_pixel(px1));

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Send one pixel and return {valid,bg,pixel} of both instances three edges later.
    task automatic send_px(input int x, input int y, output logic [2:0] r0, output logic [2:0] r1);
        pixel_valid = 1'b1;
        pixel_x = 11'(x);
        pixel_y = 11'(y);
        tick();
        pixel_valid = 1'b0;
        tick();
        tick();
        r0 = {ov0, bg0, px0};
        r1 = {ov1, bg1, px1};
    endtask

    task automatic load(input logic [31:0] v, input logic frz);
        values = v;
        freeze = frz;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        logic [2:0] r0, r1;
        reset_n = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({ov0, bg0, px0} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_out0: got %b expected 000", {ov0, bg0, px0});
        end
        n_cmp++;
        if ({ov1, bg1, px1} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_out1: got %b expected 000", {ov1, bg1, px1});
        end
        reset_n = 1'b1;
        tick();
        send_px(17, 10, r0, r1);
        n_cmp++;
        if (r0 !== 3'b111) begin
            n_bad++;
            $display("FAIL reset_snapshot_zero: got %b expected 111", r0);
        end
        tick();
        n_cmp++;
        if ({ov0, bg0, px0} !== 3'b000) begin
            n_bad++;
            $display("FAIL idle_after_pixel: got %b expected 000", {ov0, bg0, px0});
        end
    endtask

    task automatic test_glyphs();
        int         xs[8]  = '{19, 18, 25, 30, 28, 16, 47, 17};
        int         ys[8]  = '{10, 10, 11, 11, 11, 8, 23, 12};
        logic [2:0] exp[8] = '{3'b111, 3'b110, 3'b111, 3'b111, 3'b110, 3'b110, 3'b110, 3'b110};
        logic [2:0] r0, r1;
        load(32'h0000_1000, 1'b0);
        for (int i = 0; i < 8; i++) begin
            send_px(xs[i], ys[i], r0, r1);
            n_cmp++;
            if (r0 !== exp[i]) begin
                n_bad++;
                $display("FAIL glyph(%0d,%0d): got %b expected %b", xs[i], ys[i], r0, exp[i]);
            end
        end
    endtask

    task automatic test_boundary();
        int         xs[4] = '{15, 48, 16, 16};
        int         ys[4] = '{8, 8, 7, 24};
        logic [2:0] r0, r1;
        for (int i = 0; i < 4; i++) begin
            send_px(xs[i], ys[i], r0, r1);
            n_cmp++;
            if (r0 !== 3'b100) begin
                n_bad++;
                $display("FAIL outside(%0d,%0d): got %b expected 100", xs[i], ys[i], r0);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] r0, r1;
        values = 32'h0000_F000;
        frame_start = 1'b1;
        pixel_valid = 1'b1;
        pixel_x = 11'd17;
        pixel_y = 11'd10;
        tick();
        frame_start = 1'b0;
        tick();
        pixel_valid = 1'b0;
        tick();
        n_cmp++;
        if ({ov0, bg0, px0} !== 3'b110) begin
            n_bad++;
            $display("FAIL same_cycle_old_snapshot: got %b expected 110", {ov0, bg0, px0});
        end
        tick();
        n_cmp++;
        if ({ov0, bg0, px0} !== 3'b111) begin
            n_bad++;
            $display("FAIL next_cycle_new_snapshot: got %b expected 111", {ov0, bg0, px0});
        end
        send_px(16, 10, r0, r1);
        n_cmp++;
        if (r0 !== 3'b110) begin
            n_bad++;
            $display("FAIL F_col0: got %b expected 110", r0);
        end
    endtask

    task automatic test_freeze();
        logic [2:0] r0, r1;
        load(32'h0000_0000, 1'b1);
        send_px(19, 12, r0, r1);
        n_cmp++;
        if (r0 !== 3'b111) begin
            n_bad++;
            $display("FAIL frozen_keeps_F: got %b expected 111", r0);
        end
        freeze = 1'b0;
        tick();
        send_px(19, 12, r0, r1);
        n_cmp++;
        if (r0 !== 3'b111) begin
            n_bad++;
            $display("FAIL unfreeze_no_frame: got %b expected 111", r0);
        end
        load(32'h0000_0000, 1'b0);
        send_px(19, 12, r0, r1);
        n_cmp++;
        if (r0 !== 3'b110) begin
            n_bad++;
            $display("FAIL reload_zero: got %b expected 110", r0);
        end
    endtask

    task automatic test_scale();
        int         xs[5]  = '{22, 23, 22, 79, 80};
        int         ys[5]  = '{12, 13, 13, 12, 12};
        logic [2:0] exp[5] = '{3'b111, 3'b111, 3'b111, 3'b110, 3'b100};
        logic [2:0] r0, r1;
        load(32'h0000_1000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            send_px(xs[i], ys[i], r0, r1);
            n_cmp++;
            if (r1 !== exp[i]) begin
                n_bad++;
                $display("FAIL scale2(%0d,%0d): got %b expected %b", xs[i], ys[i], r1, exp[i]);
            end
        end
    endtask

    task automatic test_midstream_reset();
        logic [2:0] r0, r1;
        pixel_valid = 1'b1;
        pixel_x = 11'd19;
        pixel_y = 11'd10;
        tick();
        pixel_x = 11'd25;
        pixel_y = 11'd11;
        tick();
        pixel_x = 11'd30;
        reset_n = 1'b0;
        tick();
        pixel_valid = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({ov0, bg0, px0} !== 3'b000) begin
                n_bad++;
                $display("FAIL flush_cycle%0d: got %b expected 000", i, {ov0, bg0, px0});
            end
            tick();
        end
        send_px(17, 10, r0, r1);
        n_cmp++;
        if (r0 !== 3'b111) begin
            n_bad++;
            $display("FAIL post_reset_zero_glyph: got %b expected 111", r0);
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_glyphs();
        test_boundary();
        test_back_to_back();
        test_freeze();
        test_scale();
        test_midstream_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/debug_hex_overlay.md
Name: debug_hex_overlay

Overview:
Streaming hex-value text overlay for the debug video path. It snapshots NUM_CHANNELS debug values once per frame and maps incoming raster coordinates onto an 8x8 hex glyph grid, one channel per text row, with integer pixel scaling. It emits a registered glyph pixel and a background-box flag that the video mixer composites over the normal output.

Parameters:
NUM_CHANNELS, 2, number of displayed values (text rows)
DIGITS, 4, hex digits per value; each value is DIGITS*4 bits
COORD_W, 11, width of pixel_x/pixel_y
ORIGIN_X, 16, left pixel column of the text box
ORIGIN_Y, 8, top pixel row of the text box
SCALE_LOG2, 0, glyph scale as 2^SCALE_LOG2 (legal 0..2)

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous active-low reset
frame_start  in  1  one-cycle pulse at start of frame; triggers snapshot
freeze  in  1  when 1, frame_start does not update the snapshot
values  in  NUM_CHANNELS*DIGITS*4  packed values; channel c at bits [c*DIGITS*4 +: DIGITS*4]
pixel_valid  in  1  pixel_x/pixel_y valid this cycle
pixel_x  in  COORD_W  raster column
pixel_y  in  COORD_W  raster row
overlay_valid  out  1  pixel_valid delayed 3 cycles
overlay_bg  out  1  pixel lies inside the text box
overlay_pixel  out  1  glyph foreground bit (implies overlay_bg)

Behaviour:
- Reset: synchronous, active-low. Sampled low: all snapshot registers cleared to 0, all pipeline valid bits cleared. overlay_valid/overlay_bg/overlay_pixel are 0 from the next edge and remain 0 until 3 cycles after the first post-reset pixel_valid. Reset mid-stream discards all in-flight pixels.
- Snapshot: at a clock edge with frame_start=1 and freeze=0, snapshot <= values. Otherwise the snapshot holds.
- Layout: cell = 8<<SCALE_LOG2 pixels square. dx = pixel_x-ORIGIN_X and dy = pixel_y-ORIGIN_Y, computed unsigned with a borrow bit. Inside box iff there is no borrow, dx < DIGITS*cell and dy < NUM_CHANNELS*cell.
- Cell decode:
  - digit index d = dx >> (3+SCALE_LOG2); d=0 is the most significant nibble.
  - channel c = dy >> (3+SCALE_LOG2).
  - glyph column gx = (dx >> SCALE_LOG2) & 7; glyph row gy = (dy >> SCALE_LOG2) & 7.
- Pipeline: fixed 3 cycles, no stalls, one pixel per cycle.
  - S1: compute the inside flag, c, d, gx and gy. Select nibble = snapshot[c][(DIGITS-1-d)*4 +: 4] from the snapshot value present in that cycle.
  - S2: register glyph row = font[nibble][gy].
  - S3: overlay_pixel = inside & valid & row bit (7-gx), so the MSB is the leftmost pixel. overlay_bg = inside & valid. overlay_valid = valid.
  - Outside the box, or with pixel_valid=0: overlay_bg=0, overlay_pixel=0.
- Font: an internal 16x8 row ROM of 8-bit rows holding the standard hex debug glyphs 0-F. Rows 0, 1 and 7 of every glyph are blank. Rows used by verification:
  - '0': rows 2-6 = 01111110, 01000010, 01000010, 01000010, 01111110.
  - '1': rows 2-6 = 00010000.
  - 'F': rows 2-6 = 01111110, 01000000, 01111110, 01000000, 01000000.
- Simultaneous events:
  - frame_start and pixel_valid in the same cycle: that pixel uses the old snapshot; pixels from the next cycle on use the new one.
  - frame_start with freeze=1: ignored.
  - freeze toggled mid-frame: no visible effect until the next frame_start.
- Width rules: no wrap-around in dx/dy. Coordinates below the origin are outside the box, never aliased.

Test Plan:
- Reset, values={ch1=0x0000, ch0=0x1000}, frame_start, pixel (19,10) valid at cycle T -> at T+3: overlay_valid=1, overlay_bg=1, overlay_pixel=1 ('1' row2, col3). Pixel (18,10) -> pixel=0, bg=1.
- Same snapshot, pixel (25,11) (ch0 digit1 '0', row3, col1) -> pixel=1. Pixel (30,11) col6 -> pixel=1. Pixel (28,11) col4 -> pixel=0.
- Boundary: pixels (15,8), (48,8), (16,7), (16,24) -> overlay_valid=1, overlay_bg=0, overlay_pixel=0. Pixels (47,23) and (16,8) -> overlay_bg=1.
- Snapshot timing: values ch0=0xF000 and frame_start at cycle T, pixel (16,10) at T and again at T+1 -> outputs at T+3 use '1' (col0 row2 = 0, pixel=0); outputs at T+4 use 'F' (col0 = 0; repeat at (17,10): 0 then 1). Then freeze=1, values=0x0000, frame_start -> (17,10) still gives pixel=1.
- SCALE_LOG2=1 build, ch0=0x1000: pixels (22,12), (23,13) and (22,13) all map to '1' row2 col3 -> pixel=1. Box width = 64 px, so x=79 is inside and x=80 is outside.
- Mid-stream reset: 3 valid in-box pixels in flight, reset_n=0 for 1 cycle -> outputs 0 on the following cycles with no stale valids. Snapshot=0, so (17,10) -> '0' row2 col1 -> pixel=1.
